// File: rtl/fuq_pkg.sv
// Shared constants, entry layout and issue payload for the wakeup issue queue.
`timescale 1ns/1ps
package fuq_pkg;

  localparam int FUQ_DEPTH        = 8;
  localparam int FUQ_INST_ID_BITS = 6;
  localparam int FUQ_PRN_BITS     = 6;
  localparam int FUQ_MAX_OPERANDS = 3;
  localparam int FUQ_WAKE_PORTS   = 4;
  localparam int FUQ_INSTR_BITS   = 32;
  localparam int FUQ_PC_BITS      = 64;

  typedef struct packed {
    logic [FUQ_INST_ID_BITS-1:0]                     inst_id;
    logic [FUQ_INSTR_BITS-1:0]                       raw_instr;
    logic [FUQ_PC_BITS-1:0]                          pc;
    logic [FUQ_MAX_OPERANDS-1:0]                     src_valid;
    logic [FUQ_MAX_OPERANDS-1:0]                     src_ready;
    logic [FUQ_MAX_OPERANDS-1:0][FUQ_PRN_BITS-1:0]   src_prn;
    logic [FUQ_MAX_OPERANDS-1:0]                     dst_valid;
    logic [FUQ_MAX_OPERANDS-1:0][FUQ_PRN_BITS-1:0]   dst_prn;
  } fuq_entry_t;

  // Ready bits are consumed by selection and are not part of the issued payload.
  typedef struct packed {
    logic [FUQ_INST_ID_BITS-1:0]                     inst_id;
    logic [FUQ_INSTR_BITS-1:0]                       raw_instr;
    logic [FUQ_PC_BITS-1:0]                          pc;
    logic [FUQ_MAX_OPERANDS-1:0]                     src_valid;
    logic [FUQ_MAX_OPERANDS-1:0][FUQ_PRN_BITS-1:0]   src_prn;
    logic [FUQ_MAX_OPERANDS-1:0]                     dst_valid;
    logic [FUQ_MAX_OPERANDS-1:0][FUQ_PRN_BITS-1:0]   dst_prn;
  } fuq_issue_t;

  function automatic fuq_issue_t to_issue(input fuq_entry_t e);
    fuq_issue_t r;
    r.inst_id   = e.inst_id;
    r.raw_instr = e.raw_instr;
    r.pc        = e.pc;
    r.src_valid = e.src_valid;
    r.src_prn   = e.src_prn;
    r.dst_valid = e.dst_valid;
    r.dst_prn   = e.dst_prn;
    return r;
  endfunction

endpackage

// File: rtl/iq_age_select.sv
// Age matrix tracking insertion order of queue slots; grants the oldest candidate one-hot.
`timescale 1ns/1ps
module iq_age_select
  import fuq_pkg::*;
#(
  parameter int DEPTH = FUQ_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [DEPTH-1:0] insert_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] candidate,
  output logic [DEPTH-1:0] grant,
  output logic             grant_valid
);

  // age[i][j] set means slot i was inserted before slot j; the diagonal stays 0.
  logic [DEPTH-1:0][DEPTH-1:0] age;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age <= '0;
    end else if (flush) begin
      age <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (insert_oh[i])      age[i][j] <= 1'b0;
          else if (insert_oh[j]) age[i][j] <= 1'b1;
          else if (free_oh[i])   age[i][j] <= 1'b0;
        end
      end
    end
  end

  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = candidate[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (candidate[j] && age[j][i]) grant[i] = 1'b0;
      end
    end
  end

  assign grant_valid = |candidate;

endmodule

// File: rtl/wakeup_issue_queue.sv
// Wakeup/select issue queue with a single registered issue slot.
// Optional statistics outputs (occupancy, stall_cycles) are built when FUQ_STATS_EN is defined.
`timescale 1ns/1ps
module wakeup_issue_queue
  import fuq_pkg::*;
#(
  parameter int DEPTH        = FUQ_DEPTH,
  parameter int INST_ID_BITS = FUQ_INST_ID_BITS,
  parameter int PRN_BITS     = FUQ_PRN_BITS,
  parameter int MAX_OPERANDS = FUQ_MAX_OPERANDS,
  parameter int WAKE_PORTS   = FUQ_WAKE_PORTS
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                flush,
  input  logic                                                inst_valid,
  output logic                                                queue_ready,
  input  logic [INST_ID_BITS-1:0]                             inst_id,
  input  logic [31:0]                                         raw_instr,
  input  logic [63:0]                                         instr_pc,
  input  logic [MAX_OPERANDS-1:0]                             prn_input_valid,
  input  logic [MAX_OPERANDS-1:0]                             prn_input_ready,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               prn_input,
  input  logic [MAX_OPERANDS-1:0]                             prn_output_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               prn_output,
  input  logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0]             wake_valid,
  input  logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] wake_prn,
  output logic                                                issue_valid,
  input  logic                                                issue_ready,
  output logic [INST_ID_BITS-1:0]                             issue_inst_id,
  output logic [31:0]                                         issue_raw_instr,
  output logic [63:0]                                         issue_pc,
  output logic [MAX_OPERANDS-1:0]                             issue_prn_output_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               issue_prn_output,
  output logic [MAX_OPERANDS-1:0]                             prf_read_enable,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               prf_read_prn
`ifdef FUQ_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]                              occupancy,
  output logic [31:0]                                         stall_cycles
`endif
);

  function automatic logic wake_hit(
    input logic [PRN_BITS-1:0]                               prn,
    input logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0]           wv,
    input logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] wp
  );
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKE_PORTS; w++) begin
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        hit |= wv[w][k] && (wp[w][k] == prn);
      end
    end
    return hit;
  endfunction

  logic [DEPTH-1:0]                   valid;
  fuq_entry_t                         entries [DEPTH];
  fuq_entry_t                         ins_entry;
  fuq_entry_t                         sel_entry;
  fuq_issue_t                         issue_q;
  logic                               issue_valid_q;
  logic [DEPTH-1:0]                   free_oh, insert_oh, release_oh;
  logic [DEPTH-1:0]                   candidate, grant;
  logic [DEPTH-1:0][MAX_OPERANDS-1:0] wake_set;
  logic                               grant_valid, insert_en, load_issue;

  // Occupancy is taken from registered valids only, so a slot freed this edge waits a cycle.
  assign queue_ready = ~&valid;
  assign insert_en   = inst_valid && queue_ready && !flush;
  assign load_issue  = !flush && (!issue_valid_q || issue_ready);
  assign insert_oh   = insert_en ? free_oh : '0;
  assign release_oh  = load_issue ? grant : '0;

  always_comb begin
    free_oh = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ins_entry           = '0;
    ins_entry.inst_id   = inst_id;
    ins_entry.raw_instr = raw_instr;
    ins_entry.pc        = instr_pc;
    ins_entry.src_valid = prn_input_valid;
    ins_entry.src_prn   = prn_input;
    ins_entry.dst_valid = prn_output_valid;
    ins_entry.dst_prn   = prn_output;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      ins_entry.src_ready[k] = !prn_input_valid[k] || prn_input_ready[k] ||
                               wake_hit(prn_input[k], wake_valid, wake_prn);
    end
  end

  always_comb begin
    wake_set  = '0;
    candidate = '0;
    for (int i = 0; i < DEPTH; i++) begin
      candidate[i] = valid[i] && (&entries[i].src_ready);
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        wake_set[i][k] = wake_hit(entries[i].src_prn[k], wake_valid, wake_prn);
      end
    end
  end

  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_entry = entries[i];
    end
  end

  iq_age_select #(.DEPTH(DEPTH)) u_age_select (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .insert_oh   (insert_oh),
    .free_oh     (release_oh),
    .candidate   (candidate),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       valid <= '0;
    else if (flush) valid <= '0;
    else            valid <= (valid & ~release_oh) | insert_oh;
  end

  // NOTE: entry payload is storage qualified by valid, so it is deliberately left without reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (insert_oh[i])  entries[i] <= ins_entry;
      else if (valid[i]) entries[i].src_ready <= entries[i].src_ready | wake_set[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
    end else if (flush) begin
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
    end else if (load_issue) begin
      issue_valid_q <= grant_valid;
      if (grant_valid) issue_q <= to_issue(sel_entry);
    end
  end

  assign issue_valid            = issue_valid_q;
  assign issue_inst_id          = issue_q.inst_id;
  assign issue_raw_instr        = issue_q.raw_instr;
  assign issue_pc               = issue_q.pc;
  assign issue_prn_output_valid = issue_q.dst_valid;
  assign issue_prn_output       = issue_q.dst_prn;
  assign prf_read_enable        = {MAX_OPERANDS{issue_valid_q}} & issue_q.src_valid;
  assign prf_read_prn           = issue_q.src_prn;

`ifdef FUQ_STATS_EN
  localparam int OCC_BITS = $clog2(DEPTH) + 1;

  assign occupancy = OCC_BITS'($countones(valid));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       stall_cycles <= '0;
    else if (flush) stall_cycles <= '0;
    else if (issue_valid_q && !issue_ready && stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_wakeup_issue_queue.sv
// Self-checking bench for wakeup_issue_queue: directed scenarios plus randomized traffic vs an in-order queue model.
`timescale 1ns/1ps
module tb_wakeup_issue_queue;

  localparam int DEPTH = 8;

  logic                 clk, rst, flush, inst_valid, issue_ready;
  logic                 queue_ready, issue_valid;
  logic [5:0]           inst_id, issue_inst_id;
  logic [31:0]          raw_instr, issue_raw_instr;
  logic [63:0]          instr_pc, issue_pc;
  logic [2:0]           prn_input_valid, prn_input_ready, prn_output_valid;
  logic [2:0][5:0]      prn_input, prn_output;
  logic [3:0][2:0]      wake_valid;
  logic [3:0][2:0][5:0] wake_prn;
  logic [2:0]           issue_prn_output_valid, prf_read_enable;
  logic [2:0][5:0]      issue_prn_output, prf_read_prn;
`ifdef FUQ_STATS_EN
  logic [3:0]           occupancy;
  logic [31:0]          stall_cycles;
`endif

  wakeup_issue_queue #(
    .DEPTH(DEPTH), .INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(3), .WAKE_PORTS(4)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .flush                  (flush),
    .inst_valid             (inst_valid),
    .queue_ready            (queue_ready),
    .inst_id                (inst_id),
    .raw_instr              (raw_instr),
    .instr_pc               (instr_pc),
    .prn_input_valid        (prn_input_valid),
    .prn_input_ready        (prn_input_ready),
    .prn_input              (prn_input),
    .prn_output_valid       (prn_output_valid),
    .prn_output             (prn_output),
    .wake_valid             (wake_valid),
    .wake_prn               (wake_prn),
    .issue_valid            (issue_valid),
    .issue_ready            (issue_ready),
    .issue_inst_id          (issue_inst_id),
    .issue_raw_instr        (issue_raw_instr),
    .issue_pc               (issue_pc),
    .issue_prn_output_valid (issue_prn_output_valid),
    .issue_prn_output       (issue_prn_output),
    .prf_read_enable        (prf_read_enable),
    .prf_read_prn           (prf_read_prn)
`ifdef FUQ_STATS_EN
    ,
    .occupancy              (occupancy),
    .stall_cycles           (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  int n_checks;
  int n_fail;

  // Reference model: instructions kept in insertion order; the oldest all-ready one issues.
  typedef struct packed {
    logic [5:0]      tag;
    logic [31:0]     instr;
    logic [63:0]     pc;
    logic [2:0]      sv;
    logic [2:0]      sr;
    logic [2:0][5:0] sp;
    logic [2:0]      dv;
    logic [2:0][5:0] dp;
  } ment_t;

  ment_t mq[$];
  logic  m_iv;
  ment_t m_iss;
`ifdef FUQ_STATS_EN
  logic [31:0] m_stall;
`endif

  function automatic logic wake_hits(input logic [5:0] p);
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 3; k++)
        if (wake_valid[w][k] && wake_prn[w][k] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_edge();
    int    pre;
    int    sel;
    ment_t e;
    if (!rst || flush) begin
      mq.delete();
      m_iv = 1'b0;
`ifdef FUQ_STATS_EN
      m_stall = '0;
`endif
      return;
    end
    pre = mq.size();
    sel = -1;
`ifdef FUQ_STATS_EN
    if (m_iv && !issue_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
    if (!m_iv || issue_ready) begin
      for (int i = 0; i < mq.size(); i++)
        if (sel < 0 && mq[i].sr == 3'b111) sel = i;
      m_iv = (sel >= 0);
      if (sel >= 0) begin
        m_iss = mq[sel];
        mq.delete(sel);
      end
    end
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      for (int k = 0; k < 3; k++) if (wake_hits(e.sp[k])) e.sr[k] = 1'b1;
      mq[i] = e;
    end
    if (inst_valid && pre < DEPTH) begin
      e.tag = inst_id; e.instr = raw_instr; e.pc = instr_pc;
      e.sv = prn_input_valid; e.sp = prn_input;
      e.dv = prn_output_valid; e.dp = prn_output;
      for (int k = 0; k < 3; k++)
        e.sr[k] = !prn_input_valid[k] || prn_input_ready[k] || wake_hits(prn_input[k]);
      mq.push_back(e);
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 1'b0; inst_valid = 1'b0; inst_id = '0; raw_instr = '0; instr_pc = '0;
    prn_input_valid = '0; prn_input_ready = '0; prn_input = '0;
    prn_output_valid = '0; prn_output = '0; wake_valid = '0; wake_prn = '0;
  endtask

  task automatic drive_insert(input logic [5:0] tag, input logic [2:0] pv,
                              input logic [2:0] pr, input logic [2:0][5:0] pp);
    inst_valid       = 1'b1;
    inst_id          = tag;
    raw_instr        = 32'hF000_0000 | 32'(tag);
    instr_pc         = 64'h1000 + 64'(tag) * 64'd4;
    prn_input_valid  = pv;
    prn_input_ready  = pr;
    prn_input        = pp;
    prn_output_valid = 3'b001;
    prn_output       = {6'd0, 6'd0, tag};
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (queue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_queue_ready: got %b want 1", queue_ready); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
    n_checks++; if (prf_read_enable !== 3'b000) begin n_fail++; $display("FAIL reset_prf_en: got %b want 000", prf_read_enable); end
    n_checks++; if (issue_pc !== 64'd0 || issue_inst_id !== 6'd0) begin n_fail++; $display("FAIL reset_payload: got pc %h id %h want 0", issue_pc, issue_inst_id); end
    rst = 1'b1;
  endtask

  task automatic test_issue_basic();
    logic [2:0][5:0] exp_p;
    exp_p = {6'd3, 6'd2, 6'd1};
    issue_ready = 1'b1;
    drive_insert(6'd1, 3'b011, 3'b011, exp_p);
    tick();
    clear_inputs();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL A_not_same_edge: got %b want 0", issue_valid); end
    tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd1) begin n_fail++; $display("FAIL A_issue: got v=%b id=%0d want v=1 id=1", issue_valid, issue_inst_id); end
    n_checks++; if (prf_read_prn !== exp_p) begin n_fail++; $display("FAIL A_prf_prn: got %h want %h", prf_read_prn, exp_p); end
    n_checks++; if (prf_read_enable !== 3'b011) begin n_fail++; $display("FAIL A_prf_en: got %b want 011", prf_read_enable); end
    n_checks++; if (issue_pc !== 64'h1004) begin n_fail++; $display("FAIL A_pc: got %h want 1004", issue_pc); end
    tick();
    n_checks++; if (issue_valid !== 1'b0 || queue_ready !== 1'b1) begin n_fail++; $display("FAIL A_drain: got v=%b qr=%b want v=0 qr=1", issue_valid, queue_ready); end
  endtask

  task automatic test_wakeup();
    issue_ready = 1'b1;
    drive_insert(6'd2, 3'b001, 3'b000, {6'd0, 6'd0, 6'd5});
    tick();
    clear_inputs();
    tick();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL B_early_edge2: got %b want 0", issue_valid); end
    wake_valid[1][2] = 1'b1; wake_prn[1][2] = 6'd6;
    tick();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL B_wrong_wake: got %b want 0", issue_valid); end
    wake_valid = '0; wake_prn = '0;
    wake_valid[2][1] = 1'b1; wake_prn[2][1] = 6'd5;
    tick();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL B_wake_edge: got %b want 0", issue_valid); end
    clear_inputs();
    tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd2) begin n_fail++; $display("FAIL B_issue: got v=%b id=%0d want v=1 id=2", issue_valid, issue_inst_id); end
    n_checks++; if (prf_read_enable !== 3'b001 || prf_read_prn[0] !== 6'd5) begin n_fail++; $display("FAIL B_prf: got en=%b prn0=%0d want en=001 prn0=5", prf_read_enable, prf_read_prn[0]); end
    tick();
  endtask

  task automatic test_insert_bypass();
    issue_ready = 1'b1;
    drive_insert(6'd3, 3'b100, 3'b000, {6'd7, 6'd0, 6'd0});
    wake_valid[3][0] = 1'b1; wake_prn[3][0] = 6'd7;
    tick();
    clear_inputs();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL C_same_edge: got %b want 0", issue_valid); end
    tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd3) begin n_fail++; $display("FAIL C_bypass_issue: got v=%b id=%0d want v=1 id=3", issue_valid, issue_inst_id); end
    tick();
  endtask

  task automatic test_full_stall();
    issue_ready = 1'b0;
    for (int t = 0; t < 9; t++) begin
      drive_insert(6'(10 + t), 3'b001, 3'b001, {6'd0, 6'd0, 6'(20 + t)});
      tick();
    end
    n_checks++; if (queue_ready !== 1'b0) begin n_fail++; $display("FAIL full_queue_ready: got %b want 0", queue_ready); end
    drive_insert(6'd19, 3'b000, 3'b000, '0);
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (queue_ready !== 1'b0 || issue_valid !== 1'b1 || issue_inst_id !== 6'd10 ||
          issue_pc !== 64'h1028 || prf_read_prn[0] !== 6'd20 || prf_read_enable !== 3'b001) begin
        n_fail++;
        $display("FAIL stall_stable c%0d: got qr=%b v=%b id=%0d pc=%h prn0=%0d en=%b want qr=0 v=1 id=10 pc=1028 prn0=20 en=001",
                 c, queue_ready, issue_valid, issue_inst_id, issue_pc, prf_read_prn[0], prf_read_enable);
      end
    end
    clear_inputs();
    issue_ready = 1'b1;
    for (int t = 1; t < 9; t++) begin
      tick();
      n_checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'(10 + t)) begin n_fail++; $display("FAIL release_order %0d: got v=%b id=%0d want v=1 id=%0d", t, issue_valid, issue_inst_id, 10 + t); end
      if (t == 1) begin
        n_checks++; if (queue_ready !== 1'b1) begin n_fail++; $display("FAIL release_queue_ready: got %b want 1", queue_ready); end
      end
    end
    tick();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL release_empty: got %b want 0", issue_valid); end
  endtask

  task automatic test_flush();
    issue_ready = 1'b0;
    drive_insert(6'd20, 3'b000, 3'b000, '0);
    tick();
    clear_inputs();
    tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd20) begin n_fail++; $display("FAIL flush_pre: got v=%b id=%0d want v=1 id=20", issue_valid, issue_inst_id); end
    drive_insert(6'd21, 3'b001, 3'b000, {6'd0, 6'd0, 6'd9});
    wake_valid[0][1] = 1'b1; wake_prn[0][1] = 6'd9;
    flush = 1'b1;
    issue_ready = 1'b1;
    tick();
    clear_inputs();
    n_checks++; if (issue_valid !== 1'b0 || queue_ready !== 1'b1 || prf_read_enable !== 3'b000) begin n_fail++; $display("FAIL flush_clear: got v=%b qr=%b en=%b want v=0 qr=1 en=000", issue_valid, queue_ready, prf_read_enable); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_issue c%0d: got v=%b id=%0d want v=0", c, issue_valid, issue_inst_id); end
    end
  endtask

  task automatic test_reset_mid();
    issue_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      drive_insert(6'(30 + t), 3'b000, 3'b000, '0);
      tick();
    end
    clear_inputs();
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b want 1", issue_valid); end
    rst = 1'b0;
    #2;
    n_checks++;
    if (queue_ready !== 1'b1 || issue_valid !== 1'b0 || prf_read_enable !== 3'b000 ||
        issue_inst_id !== 6'd0 || issue_pc !== 64'd0 || issue_prn_output_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset_async: got qr=%b v=%b en=%b id=%0d pc=%h dv=%b want qr=1 v=0 en=000 id=0 pc=0 dv=000",
               queue_ready, issue_valid, prf_read_enable, issue_inst_id, issue_pc, issue_prn_output_valid);
    end
`ifdef FUQ_STATS_EN
    n_checks++; if (occupancy !== 4'd0 || stall_cycles !== 32'd0) begin n_fail++; $display("FAIL mid_reset_stats: got occ=%0d stall=%0d want 0 0", occupancy, stall_cycles); end
`endif
    tick();
    rst = 1'b1;
    issue_ready = 1'b1;
    drive_insert(6'd40, 3'b000, 3'b000, '0);
    tick();
    clear_inputs();
    tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_inst_id !== 6'd40) begin n_fail++; $display("FAIL post_reset_insert: got v=%b id=%0d want v=1 id=40", issue_valid, issue_inst_id); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      inst_valid = ($urandom_range(0, 9) < 6);
      inst_id    = 6'($urandom);
      raw_instr  = $urandom;
      instr_pc   = {$urandom, $urandom};
      for (int k = 0; k < 3; k++) begin
        prn_input_valid[k]  = 1'($urandom_range(0, 1));
        prn_input_ready[k]  = ($urandom_range(0, 3) == 0);
        prn_input[k]        = 6'($urandom_range(0, 15));
        prn_output_valid[k] = 1'($urandom_range(0, 1));
        prn_output[k]       = 6'($urandom);
      end
      for (int w = 0; w < 4; w++) begin
        for (int k = 0; k < 3; k++) begin
          wake_valid[w][k] = ($urandom_range(0, 7) == 0);
          wake_prn[w][k]   = 6'($urandom_range(0, 15));
        end
      end
      issue_ready = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 79) == 0);
      tick();
      n_checks++; if (queue_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_queue_ready c%0d: got %b want %b", c, queue_ready, (mq.size() < DEPTH)); end
      n_checks++; if (issue_valid !== m_iv) begin n_fail++; $display("FAIL rnd_issue_valid c%0d: got %b want %b", c, issue_valid, m_iv); end
      if (m_iv) begin
        n_checks++;
        if (issue_inst_id !== m_iss.tag || issue_pc !== m_iss.pc || issue_raw_instr !== m_iss.instr) begin
          n_fail++;
          $display("FAIL rnd_payload c%0d: got id=%0d pc=%h instr=%h want id=%0d pc=%h instr=%h",
                   c, issue_inst_id, issue_pc, issue_raw_instr, m_iss.tag, m_iss.pc, m_iss.instr);
        end
        n_checks++;
        if (prf_read_enable !== m_iss.sv || prf_read_prn !== m_iss.sp) begin
          n_fail++;
          $display("FAIL rnd_prf c%0d: got en=%b prn=%h want en=%b prn=%h", c, prf_read_enable, prf_read_prn, m_iss.sv, m_iss.sp);
        end
        n_checks++;
        if (issue_prn_output_valid !== m_iss.dv || issue_prn_output !== m_iss.dp) begin
          n_fail++;
          $display("FAIL rnd_dest c%0d: got dv=%b dp=%h want dv=%b dp=%h", c, issue_prn_output_valid, issue_prn_output, m_iss.dv, m_iss.dp);
        end
      end else begin
        n_checks++; if (prf_read_enable !== 3'b000) begin n_fail++; $display("FAIL rnd_prf_idle c%0d: got %b want 000", c, prf_read_enable); end
      end
`ifdef FUQ_STATS_EN
      n_checks++; if (occupancy !== 4'(mq.size()) || stall_cycles !== m_stall) begin n_fail++; $display("FAIL rnd_stats c%0d: got occ=%0d stall=%0d want occ=%0d stall=%0d", c, occupancy, stall_cycles, mq.size(), m_stall); end
`endif
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_iv     = 1'b0;
    m_iss    = '0;
`ifdef FUQ_STATS_EN
    m_stall  = '0;
`endif
    rst         = 1'b0;
    issue_ready = 1'b1;
    clear_inputs();
    test_reset();
    test_issue_basic();
    test_wakeup();
    test_insert_bypass();
    test_full_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
